gate_sweep_checker: RTL

- Hardware exhaustive-sweep checker for combinational gate blocks.
- Drives all 2^N_IN input combinations into an external gate DUT in ascending order, with the vector MSB on dut_in[N_IN-1].
- Waits a programmable settle time per vector, samples the DUT output, and compares it against a built-in reference for the selected gate function.
- Reports pass/fail, a mismatch count and the first failing vector. Sits beside gate-level blocks in self-test wrappers and replaces hand-written stimulus loops.

---
 rtl/gate_sweep_pkg.sv | 26 ++
 rtl/gate_sweep_checker_ref.sv | 29 ++
 rtl/gate_sweep_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared definitions for the gate sweep checker.
//   - OP_* : gate function encodings carried on the op port
//   - state_t : sweep FSM states
//   - is_legal_op() : true for the six implemented gate functions
package gate_sweep_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// gate_ref_model: combinational reference for the selected gate function.
// Ports:
//   op      in  3     gate function (OP_* encoding)
//   vec     in  N_IN  input vector
//   exp_bit out 1     expected gate output; 0 for reserved ops
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] vec,
    output logic            exp_bit
);

    always_comb begin
        exp_bit = 1'b0;
        case (op)
            OP_AND:  exp_bit = &vec;
            OP_OR:   exp_bit = |vec;
            OP_XOR:  exp_bit = ^vec;
            OP_NAND: exp_bit = ~&vec;
            OP_NOR:  exp_bit = ~|vec;
            OP_XNOR: exp_bit = ~^vec;
            default: exp_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input combination into an external gate,
// waits SETTLE_CYC cycles per vector, samples the gate output and compares it
// with the built-in reference. Reports pass, mismatch count and first failure.
// Optional: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first
// mismatch (dut_in then holds the failing vector).
// Ports:
//   clk, rst     clock, async active-high reset
//   start, op    sweep request and gate function (latched on acceptance)
//   dut_in       stimulus vector to the gate under test
//   dut_out      gate under test result
//   busy, done   sweep running / results valid (level)
//   pass         done with zero mismatches and a legal op
//   err_count    saturating mismatch count
//   fail_valid, fail_vec  first mismatching vector
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_vec
);

    // One extra bit so the terminal compare never aliases at N_IN=16.
    localparam logic [N_IN:0] LAST_VEC  = {1'b0, {N_IN{1'b1}}};
    localparam logic [7:0]    SETTLE_LD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

    state_t         state, state_nxt;
    logic [2:0]     op_q;
    logic [N_IN:0]  vec;
    logic [7:0]     settle_cnt;
    logic           exp_bit;
    logic           accept;
    logic           mismatch;
    logic           last_vec;
    logic           stop_early;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .op      (op_q),
        .vec     (vec[N_IN-1:0]),
        .exp_bit (exp_bit)
    );

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign mismatch = (dut_out != exp_bit);
    assign last_vec = (vec == LAST_VEC);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign stop_early = mismatch;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // Reserved ops finish immediately with nothing driven.
            ST_IDLE, ST_DONE: if (start) state_nxt = is_legal_op(op) ? ST_DRIVE : ST_DONE;
            ST_DRIVE:         state_nxt = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE:        if (settle_cnt == 8'd0) state_nxt = ST_CHECK;
            ST_CHECK:         state_nxt = (last_vec || stop_early) ? ST_DONE : ST_DRIVE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            if (accept) begin
                op_q       <= op;
                vec        <= '0;
                err_count  <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= '0;
            end

            if (state == ST_DRIVE)
                settle_cnt <= SETTLE_LD;
            else if (state == ST_SETTLE && settle_cnt != 8'd0)
                settle_cnt <= settle_cnt - 8'd1;

            if (state == ST_CHECK) begin
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_vec   <= vec[N_IN-1:0];
                        fail_valid <= 1'b1;
                    end
                end
                // Hold the vector on the last/stopping check so dut_in keeps it in DONE.
                if (!last_vec && !stop_early) vec <= vec + 1'b1;
            end
        end
    end

    assign dut_in = vec[N_IN-1:0];
    assign busy   = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign done   = (state == ST_DONE);
    assign pass   = done && (err_count == '0) && is_legal_op(op_q);

endmodule
